processor_mc: RTL and testbench

//  Multi-cycle 18-bit-class CPU core, successor of the single-cycle core: width-parametrised, adds

---
 rtl/processor_mc.sv | 230 +++++++++++++++++++++++
 tb/tb_processor_mc.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/processor_mc.sv
// processor_mc: multi-cycle CPU core with 8 GPRs, loads/stores over a req/ready data bus,
// reg-reg ALU ops, branches, call and HALT.
// Instruction flow: FETCH -> EXEC -> (MEM ->) FETCH, with HALT as a terminal state.
// Optional feature macro PROCESSOR_MUL_EN: op 3 funct 8 becomes an unsigned multiply.
// Without the macro, funct 8 retires without writing a register.
module processor_mc #(
    parameter int                   ADDR_SIZE = 18,
    parameter int                   WORD_SIZE = 18,
    parameter logic [ADDR_SIZE-1:0] RESET_IP  = {ADDR_SIZE{1'b0}}
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic [ADDR_SIZE-1:0] code_addr,
    input  logic [WORD_SIZE-1:0] code_word,
    output logic                 data_req,
    output logic                 data_write_enable,
    output logic [ADDR_SIZE-1:0] data_addr,
    output logic [WORD_SIZE-1:0] data_in,
    input  logic [WORD_SIZE-1:0] data_out,
    input  logic                 data_ready,
    output logic                 halted,
    output logic                 retire
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_MEM   = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    // Sign-extension helpers for the immediate fields
    function automatic logic [WORD_SIZE-1:0] sext8(input logic [7:0] v);
        return WORD_SIZE'($signed(v));
    endfunction

    function automatic logic [WORD_SIZE-1:0] sext11(input logic [10:0] v);
        return WORD_SIZE'($signed(v));
    endfunction

    function automatic logic [WORD_SIZE-1:0] sext18(input logic [17:0] v);
        return WORD_SIZE'($signed(v));
    endfunction

    logic [1:0]           state_q,  state_d;
    logic [ADDR_SIZE-1:0] ip_q,     ip_d;
    logic [WORD_SIZE-1:0] regs_q [8];
    logic [WORD_SIZE-1:0] regs_d [8];
    logic                 req_q,    req_d;
    logic                 we_q,     we_d;
    logic [ADDR_SIZE-1:0] addr_q,   addr_d;
    logic [WORD_SIZE-1:0] din_q,    din_d;
    logic                 halted_q, halted_d;
    logic                 retire_q, retire_d;
    logic [2:0]           ld_rx_q,  ld_rx_d;

    // Decoded instruction fields (code_word is valid during EXEC)
    logic [3:0]           op_s;
    logic [2:0]           rx_s;
    logic [2:0]           ry_s;
    logic [3:0]           funct_s;
    logic [7:0]           imm8_s;
    logic [10:0]          imm11_s;
    logic [WORD_SIZE-1:0] rx_val_s;
    logic [WORD_SIZE-1:0] ry_val_s;
    logic [WORD_SIZE-1:0] simm8_s;
    logic [WORD_SIZE-1:0] simm11_s;
    logic [WORD_SIZE-1:0] upper_s;
    logic [WORD_SIZE-1:0] eff_s;
    logic [ADDR_SIZE-1:0] eff_addr_s;
    logic [ADDR_SIZE-1:0] ip_inc_s;
    logic [ADDR_SIZE-1:0] ip_br_s;
    logic [WORD_SIZE-1:0] link_s;
    logic [WORD_SIZE-1:0] alu_res_s;
    logic                 alu_wr_s;

    assign op_s     = code_word[17:14];
    assign rx_s     = code_word[13:11];
    assign ry_s     = code_word[10:8];
    assign funct_s  = code_word[7:4];
    assign imm8_s   = code_word[7:0];
    assign imm11_s  = code_word[10:0];
    assign rx_val_s = regs_q[rx_s];
    assign ry_val_s = regs_q[ry_s];
    assign simm8_s  = sext8(imm8_s);
    assign simm11_s = sext11(imm11_s);
    // Upper-immediate: imm11 shifted left by 7, vacated bits filled with imm11 sign bit
    assign upper_s  = sext18({imm11_s, {7{imm11_s[10]}}});
    // Effective address and call target share the ry + simm8 sum (uses pre-write ry)
    assign eff_s      = ry_val_s + simm8_s;
    assign eff_addr_s = ADDR_SIZE'(eff_s);
    assign ip_inc_s   = ip_q + ADDR_SIZE'(1'b1);
    assign ip_br_s    = ip_q + ADDR_SIZE'($signed(imm11_s));
    assign link_s     = WORD_SIZE'(ip_inc_s);

    // Registered outputs straight from state
    assign code_addr         = ip_q;
    assign data_req          = req_q;
    assign data_write_enable = we_q;
    assign data_addr         = addr_q;
    assign data_in           = din_q;
    assign halted            = halted_q;
    assign retire            = retire_q;

    // Reg-reg ALU result; unsupported functs leave rx untouched
    always_comb begin
        alu_res_s = rx_val_s;
        alu_wr_s  = 1'b1;
        case (funct_s)
            4'd0: alu_res_s = rx_val_s + ry_val_s;
            4'd1: alu_res_s = rx_val_s - ry_val_s;
            4'd2: alu_res_s = rx_val_s & ry_val_s;
            4'd3: alu_res_s = rx_val_s | ry_val_s;
            4'd4: alu_res_s = rx_val_s ^ ry_val_s;
            4'd5: alu_res_s = {rx_val_s[WORD_SIZE-2:0], 1'b0};
            4'd6: alu_res_s = {1'b0, rx_val_s[WORD_SIZE-1:1]};
`ifdef PROCESSOR_MUL_EN
            4'd8: alu_res_s = rx_val_s * ry_val_s;
`endif
            default: alu_wr_s = 1'b0;
        endcase
    end

    // Next-state logic: FSM sequencing, register writeback, ip update, bus requests
    always_comb begin
        state_d  = state_q;
        ip_d     = ip_q;
        regs_d   = regs_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        din_d    = din_q;
        halted_d = halted_q;
        retire_d = 1'b0;
        ld_rx_d  = ld_rx_q;
        case (state_q)
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                state_d  = ST_FETCH;
                ip_d     = ip_inc_s;
                retire_d = 1'b1;
                case (op_s)
                    4'd0: regs_d[rx_s] = eff_s;
                    4'd1: regs_d[rx_s] = simm11_s;
                    4'd2: regs_d[rx_s] = upper_s;
                    4'd3: begin
                        if (alu_wr_s) begin
                            regs_d[rx_s] = alu_res_s;
                        end else begin
                            regs_d[rx_s] = rx_val_s;
                        end
                    end
                    4'd4, 4'd5: begin
                        // Bus access: ip and retire wait for the completing handshake
                        state_d  = ST_MEM;
                        ip_d     = ip_q;
                        retire_d = 1'b0;
                        req_d    = 1'b1;
                        we_d     = (op_s == 4'd4);
                        addr_d   = eff_addr_s;
                        din_d    = rx_val_s;
                        ld_rx_d  = rx_s;
                    end
                    4'd6: begin
                        if (rx_val_s != {WORD_SIZE{1'b0}}) begin
                            ip_d = ip_br_s;
                        end else begin
                            ip_d = ip_inc_s;
                        end
                    end
                    4'd7: begin
                        regs_d[rx_s] = link_s;
                        ip_d         = eff_addr_s;
                    end
                    4'd15: begin
                        state_d  = ST_HALT;
                        ip_d     = ip_q;
                        halted_d = 1'b1;
                    end
                    default: ip_d = ip_inc_s;
                endcase
            end
            ST_MEM: begin
                if (data_ready) begin
                    if (!we_q) begin
                        regs_d[ld_rx_q] = data_out;
                    end else begin
                        regs_d[ld_rx_q] = regs_q[ld_rx_q];
                    end
                    req_d    = 1'b0;
                    ip_d     = ip_inc_s;
                    retire_d = 1'b1;
                    state_d  = ST_FETCH;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_FETCH;
            ip_q     <= RESET_IP;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= {WORD_SIZE{1'b0}};
            end
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= {ADDR_SIZE{1'b0}};
            din_q    <= {WORD_SIZE{1'b0}};
            halted_q <= 1'b0;
            retire_q <= 1'b0;
            ld_rx_q  <= 3'd0;
        end else begin
            state_q  <= state_d;
            ip_q     <= ip_d;
            regs_q   <= regs_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            halted_q <= halted_d;
            retire_q <= retire_d;
            ld_rx_q  <= ld_rx_d;
        end
    end

endmodule

// File: tb/tb_processor_mc.sv
// Directed testbench for processor_mc (default 18-bit configuration).
// Registers are observed through store transactions on the data bus.
module tb_processor_mc;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [17:0] code_addr;
    logic [17:0] code_word = 18'h0;
    logic        data_req;
    logic        data_write_enable;
    logic [17:0] data_addr;
    logic [17:0] data_in;
    logic [17:0] data_out = 18'h0;
    logic        data_ready = 1'b0;
    logic        halted;
    logic        retire;

    int checks = 0;
    int errors = 0;

    logic [17:0] rom [0:255];
    logic [17:0] mem [0:255];

    int          tr_q [$];
    int          tr_exp [$];
    logic [17:0] st_addr [$];
    logic [17:0] st_data [$];
    logic [17:0] exp_addr [9];
    logic [17:0] exp_data [9];

    processor_mc dut (
        .clock             (clock),
        .reset             (rst_n),
        .code_addr         (code_addr),
        .code_word         (code_word),
        .data_req          (data_req),
        .data_write_enable (data_write_enable),
        .data_addr         (data_addr),
        .data_in           (data_in),
        .data_out          (data_out),
        .data_ready        (data_ready),
        .halted            (halted),
        .retire            (retire)
    );

    always #5 clock = ~clock;

    // Synchronous code ROM: word appears one cycle after the address
    always @(posedge clock) code_word <= rom[code_addr[7:0]];

    function automatic logic [17:0] e8(input int op, input int rx, input int ry, input int imm);
        return {op[3:0], rx[2:0], ry[2:0], imm[7:0]};
    endfunction

    function automatic logic [17:0] e11(input int op, input int rx, input int imm);
        return {op[3:0], rx[2:0], imm[10:0]};
    endfunction

    function automatic logic [17:0] alu(input int rx, input int ry, input int funct);
        return {4'd3, rx[2:0], ry[2:0], funct[3:0], 4'd0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_prog1();
        for (int i = 0; i < 256; i++) rom[i] = 18'h3C000;  // HALT traps everywhere
        rom[0]  = e11(1, 1, 5);            // r1 = 5
        rom[1]  = e8(0, 2, 1, -3);         // r2 = r1 - 3 = 2
        rom[2]  = e11(2, 5, 'h400);        // r5 = 0x2007F
        rom[3]  = e11(2, 3, 'h024);        // r3 = 0x1200
        rom[4]  = e8(0, 3, 3, 'h34);       // r3 = 0x1234
        rom[5]  = e8(4, 3, 1, 4);          // mem[9] = r3
        rom[6]  = e11(1, 4, 3);            // r4 = 3
        rom[7]  = e11(6, 4, 3);            // jnz r4 -> 10
        rom[8]  = e11(1, 4, 0);            // r4 = 0
        rom[9]  = e8(8, 0, 0, 0);          // nop opcode
        rom[10] = e11(6, 4, -2);           // jnz r4 -> 8 / fall to 11
        rom[11] = e8(5, 6, 1, 4);          // r6 = mem[9]
        rom[12] = e11(1, 7, 20);           // r7 = 20
        rom[13] = e8(7, 7, 7, 0);          // call r7 -> 20, r7 = 14
        rom[20] = e11(1, 1, 7);            // r1 = 7
        rom[21] = e11(1, 2, 6);            // r2 = 6
        rom[22] = e8(4, 5, 7, 8);          // mem[22] = r5
        rom[23] = alu(1, 2, 8);            // mul or nop
        rom[24] = alu(3, 5, 2);            // r3 = r3 & r5 = 0x34
        rom[25] = alu(5, 0, 5);            // r5 = shl1 -> 0xFE
        rom[26] = alu(2, 3, 1);            // r2 = 6 - 0x34
        rom[27] = alu(4, 2, 4);            // r4 = 0 ^ r2
        rom[28] = alu(4, 0, 6);            // r4 = shr1
        rom[29] = alu(0, 3, 3);            // r0 = 0 | 0x34
        rom[30] = alu(0, 0, 0);            // r0 = 0x68
        rom[31] = alu(0, 0, 7);            // undefined funct: no write
        for (int k = 0; k < 8; k++) rom[32+k] = e8(4, k, 7, k);  // mem[14+k] = rk
        rom[40] = 18'h3C000;               // HALT
    endtask

    initial begin
        int cyc;
        logic [17:0] frozen;

        load_prog1();
        for (int i = 0; i < 256; i++) mem[i] = 18'h0;
        #12;
        chk("rst_code_addr", code_addr, 0);
        chk("rst_req", data_req, 0);
        chk("rst_we", data_write_enable, 0);
        chk("rst_addr", data_addr, 0);
        chk("rst_din", data_in, 0);
        chk("rst_halted", halted, 0);
        chk("rst_retire", retire, 0);
        @(negedge clock) rst_n = 1'b1;

        // Two cycles per ALU instruction
        tick(); chk("t1_ip", code_addr, 0); chk("t1_ret", retire, 0);
        tick(); chk("t2_ip", code_addr, 1); chk("t2_ret", retire, 1);
        tick(); chk("t3_ip", code_addr, 1); chk("t3_ret", retire, 0);
        tick(); chk("t4_ip", code_addr, 2); chk("t4_ret", retire, 1);
        for (int k = 5; k <= 10; k++) begin
            tick(); chk("alt_ret", retire, (k % 2 == 0) ? 1 : 0);
        end
        chk("t10_ip", code_addr, 5);

        // Store with a slow bus
        tick(); tick();
        chk("st_req", data_req, 1); chk("st_we", data_write_enable, 1);
        chk("st_addr", data_addr, 9); chk("st_din", data_in, 'h1234);
        chk("st_ret", retire, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("st_hold_req", data_req, 1); chk("st_hold_addr", data_addr, 9);
            chk("st_hold_din", data_in, 'h1234); chk("st_hold_ret", retire, 0);
            chk("st_hold_ip", code_addr, 5);
        end
        mem[data_addr[7:0]] = data_in;
        data_ready = 1'b1;
        tick();
        chk("st_done_ret", retire, 1); chk("st_done_req", data_req, 0);
        chk("st_done_ip", code_addr, 6);
        data_ready = 1'b0;

        // Free-running section with a one-wait-cycle bus responder
        cyc = 0;
        while (!halted && cyc < 1000) begin
            if (data_req && !data_ready) begin
                if (data_write_enable) begin
                    st_addr.push_back(data_addr);
                    st_data.push_back(data_in);
                    mem[data_addr[7:0]] = data_in;
                end else begin
                    data_out = mem[data_addr[7:0]];
                end
                data_ready = 1'b1;
            end else begin
                data_ready = 1'b0;
            end
            if (retire) tr_q.push_back(int'(code_addr));
            tick();
            cyc++;
        end
        data_ready = 1'b0;
        chk("run_in_budget", (cyc < 1000) ? 1 : 0, 1);
        chk("halted", halted, 1);

        tr_exp = '{6, 7, 10, 8, 9, 10, 11, 12, 13, 20};
        for (int k = 21; k <= 40; k++) tr_exp.push_back(k);
        chk("trace_len", tr_q.size(), tr_exp.size());
        for (int i = 0; i < tr_exp.size(); i++) begin
            chk("trace_ip", (i < tr_q.size()) ? tr_q[i] : -1, tr_exp[i]);
        end

        exp_addr[0] = 18'd22; exp_data[0] = 18'h2007F;
        exp_addr[1] = 18'd14; exp_data[1] = 18'h00068;
`ifdef PROCESSOR_MUL_EN
        exp_addr[2] = 18'd15; exp_data[2] = 18'd42;
`else
        exp_addr[2] = 18'd15; exp_data[2] = 18'd7;
`endif
        exp_addr[3] = 18'd16; exp_data[3] = 18'h3FFD2;
        exp_addr[4] = 18'd17; exp_data[4] = 18'h00034;
        exp_addr[5] = 18'd18; exp_data[5] = 18'h1FFE9;
        exp_addr[6] = 18'd19; exp_data[6] = 18'h000FE;
        exp_addr[7] = 18'd20; exp_data[7] = 18'h01234;
        exp_addr[8] = 18'd21; exp_data[8] = 18'd14;
        chk("store_count", st_addr.size(), 9);
        for (int i = 0; i < 9; i++) begin
            chk("store_addr", (i < st_addr.size()) ? st_addr[i] : 18'h3FFFF, exp_addr[i]);
            chk("store_data", (i < st_data.size()) ? st_data[i] : 18'h3FFFF, exp_data[i]);
        end

        // HALT freezes the core
        frozen = code_addr;
        chk("halt_ip", frozen, 40);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("halt_frozen_ip", code_addr, 40);
            chk("halt_no_ret", retire, 0);
            chk("halt_still", halted, 1);
        end

        // Reset during a stalled bus access
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        chk("mid_req", data_req, 1);
        tick(); tick();
        chk("mid_wait_req", data_req, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mrst_req", data_req, 0);
        chk("mrst_ip", code_addr, 0);
        chk("mrst_we", data_write_enable, 0);
        chk("mrst_addr", data_addr, 0);
        chk("mrst_din", data_in, 0);
        chk("mrst_ret", retire, 0);
        chk("mrst_halted", halted, 0);
        rom[0] = e8(4, 2, 5, 3);           // mem[r5+3] = r2 (both zero after reset)
        rom[1] = 18'h3C000;
        tick();
        @(negedge clock) rst_n = 1'b1;
        tick(); chk("rs_ip0", code_addr, 0);
        tick();
        chk("rs_req", data_req, 1); chk("rs_addr", data_addr, 3);
        chk("rs_din", data_in, 0); chk("rs_we", data_write_enable, 1);
        data_ready = 1'b1;
        tick();
        chk("rs_ret", retire, 1); chk("rs_req_done", data_req, 0);
        chk("rs_ip1", code_addr, 1);
        data_ready = 1'b0;
        tick(); tick();
        chk("rs_halted", halted, 1); chk("rs_halt_ret", retire, 1);
        chk("rs_halt_ip", code_addr, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
